mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns one load/store per instruction into a req/ack transaction on the data-memory (DRAM) bus.
- Forms store byte lanes and sign/zero-extends load data.
- Stalls the pipeline for the duration of the access and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max REQ-state cycles without dram_ack before the access aborts with bus_err (1..255).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- mem_read  in  1  load request, from EX/MEM.
- mem_write  in  1  store request, from EX/MEM; has priority if both mem_read and mem_write are high.
- mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
- addr  in  32  byte address (EX/MEM ALU result).
- store_data  in  32  store source (EX/MEM reg data2); low bits are used for byte/half.
- stall  out  1  holds PC/IF/ID/EX/MEM registers while high.
- load_data  out  32  extended load result; valid when load_valid=1.
- load_valid  out  1  one-cycle pulse in DONE for a completed, non-faulting load.
- misalign  out  1  one-cycle pulse in DONE for a misaligned access.
- bus_err  out  1  one-cycle pulse in DONE for a timed-out access.
- dram_req  out  1  bus request; held until ack or timeout.
- dram_we  out  1  1 = write.
- dram_addr  out  32  word address {addr[31:2],2'b00}.
- dram_wstrb  out  4  byte enables (writes); 0000 for reads.
- dram_wdata  out  32  lane-replicated store data.
- dram_ack  in  1  single-cycle completion from memory.
- dram_rdata  in  32  read word, valid with dram_ack.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, timeout counter=0. All outputs are 0: stall, load_data, load_valid, misalign, bus_err, dram_req, dram_we, dram_addr, dram_wstrb, dram_wdata.
- States are IDLE, REQ and DONE.
- access = mem_read | mem_write.
- stall = (IDLE & access) | REQ. This is combinational and is 0 in DONE.
- IDLE, no access: stay in IDLE; all outputs 0.
- IDLE, access and aligned: register dram_we, dram_addr, dram_wstrb, dram_wdata, and the load byte offset/size/unsigned; clear counter; go to REQ. dram_req=1 from the next cycle.
- IDLE, access and misaligned (half with addr[0]=1; word with addr[1:0]!=0): no bus request; go to DONE with misalign=1.
- REQ: dram_req=1 and the bus fields are held stable. Counter increments each cycle.
  - dram_ack=1: capture the extended dram_rdata into load_data (loads only); go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: drop dram_req; go to DONE with bus_err=1 and load_data=0.
  - A late ack after abort is ignored.
- DONE: exactly one cycle.
  - load_valid = loaded & !misalign & !bus_err.
  - dram_req=0.
  - Always return to IDLE. The EX/MEM inputs are still those of the finished instruction, so DONE must not restart the access.
  - load_data holds its value until the next load completes.
- Timing: with a zero-wait memory (ack in the first REQ cycle), each access occupies 3 cycles: IDLE (stall), REQ (stall), DONE. Each extra ack wait adds 1 cycle.
- Store lanes, with o = addr[1:0]:
  - byte: wstrb = 0001<<o; wdata = {4{sd[7:0]}}.
  - half: wstrb = addr[1] ? 1100 : 0011; wdata = {2{sd[15:0]}}.
  - word: wstrb = 1111; wdata = sd.
- Load extract: byte = rdata[8o+7:8o]; half = rdata[16*addr[1]+15:16*addr[1]]; word = rdata. Extend byte/half per mem_unsigned; word is unaffected.
- Outputs are registered except stall.
- rst during REQ: dram_req=0 after that edge and state=IDLE. The memory must tolerate an abandoned request.

Test Plan:
- Word store: addr=0x100, store_data=0xDEADBEEF, ack in first REQ cycle -> dram_we=1, dram_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; stall high 2 cycles; total 3 cycles.
- Byte loads: addr=0x203, rdata=0x80AABBCC, signed -> load_data=0xFFFFFF80, load_valid pulse in DONE; repeat unsigned -> 0x00000080.
- Half store: addr=0x042, sd=0x00001234 -> dram_addr=0x040, wstrb=1100, wdata=0x12341234.
- Misaligned word load: addr=0x101 -> no dram_req; stall 1 cycle; misalign pulse; load_valid=0.
- Timeout: load with no ack, TIMEOUT_CYCLES=4 -> dram_req high 4 cycles then 0; bus_err pulse; load_data=0; an ack injected afterwards is ignored.
- rst asserted in 2nd REQ cycle with an 8-cycle ack delay -> next cycle dram_req=0, stall=0, all outputs 0; a fresh access afterwards completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives one req/ack DRAM transaction per access,
// forms store byte lanes, extends load data and flags misalignment/timeouts.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [3:0]  dram_wstrb,
    output logic [31:0] dram_wdata,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] off,
                                            input logic uns, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return {{24{~uns & b[7]}}, b};
            2'b01:   return {{16{~uns & h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic        access_s;

    assign access_s = mem_read | mem_write;

    // Next-state and next-output computation for the IDLE/REQ/DONE sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        strb_d       = strb_q;
        wdata_d      = wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access_s) begin
                    if (is_misaligned(mem_size, addr[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d   = S_REQ;
                        cnt_d     = 8'd0;
                        req_d     = 1'b1;
                        we_d      = mem_write;
                        addr_d    = {addr[31:2], 2'b00};
                        strb_d    = mem_write ? lane_strb(mem_size, addr[1:0]) : 4'b0000;
                        wdata_d   = lane_wdata(mem_size, store_data);
                        is_load_d = ~mem_write;
                        off_d     = addr[1:0];
                        size_d    = mem_size;
                        uns_d     = mem_unsigned;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // Ack wins over a timeout landing in the same cycle.
                if (dram_ack || (cnt_q >= CNT_LAST)) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'd0;
                    strb_d  = 4'b0000;
                    wdata_d = 32'd0;
                    if (dram_ack) begin
                        if (is_load_q) begin
                            load_data_d  = extract(size_q, off_q, uns_q, dram_rdata);
                            load_valid_d = 1'b1;
                        end else begin
                            load_data_d = load_data_q;
                        end
                    end else begin
                        bus_err_d   = 1'b1;
                        load_data_d = 32'd0;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                // Inputs still hold the finished instruction, so never restart here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            is_load_q    <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            strb_q       <= 4'b0000;
            wdata_q      <= 32'd0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            strb_q       <= strb_d;
            wdata_q      <= wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign stall      = ((state_q == S_IDLE) & access_s) | (state_q == S_REQ);
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;
    assign dram_req   = req_q;
    assign dram_we    = we_q;
    assign dram_addr  = addr_q;
    assign dram_wstrb = strb_q;
    assign dram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a byte-level reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic        stall, load_valid, misalign, bus_err, dram_req, dram_we;
    logic [31:0] load_data, dram_addr, dram_wdata;
    logic [3:0]  dram_wstrb;
    logic        dram_ack = 1'b0;
    logic [31:0] dram_rdata = 32'd0;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
        .store_data(store_data), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .misalign(misalign), .bus_err(bus_err),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wstrb(dram_wstrb), .dram_wdata(dram_wdata),
        .dram_ack(dram_ack), .dram_rdata(dram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } bus_t;
    typedef struct { logic mis; logic berr; logic lv; logic [31:0] ld; int stall_len; } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cur_delay = 0;
    logic [31:0] cur_rdata = 32'd0;
    logic [31:0] model_load = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_strb(input int off, input int n);
        logic [3:0] s;
        s = 4'b0000;
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + n);
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input int n);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rw, input int off, input int n, input logic u);
        logic [31:0] v, mask;
        if (n == 4) return rw;
        v = rw >> (8 * off);
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!u && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Issue one EX/MEM access, queue its expected bus transaction and completion.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] sd, input int delay,
                         input logic [31:0] rw);
        int n, off;
        bit seen;
        bus_t b;
        done_t e;
        n = nbytes(sz);
        off = int'(a[1:0]);
        e.mis = (off % n) != 0;
        e.berr = 1'b0;
        e.lv = 1'b0;
        if (e.mis) begin
            e.stall_len = 1;
        end else begin
            b.we = wr;
            b.addr = a & 32'hFFFF_FFFC;
            b.strb = wr ? ref_strb(off, n) : 4'b0000;
            b.wdata = ref_wdata(sd, n);
            bus_q.push_back(b);
            if (delay >= TO) begin
                e.berr = 1'b1;
                model_load = 32'd0;
                e.stall_len = 1 + TO;
            end else begin
                e.stall_len = 2 + delay;
                if (!wr) begin
                    e.lv = 1'b1;
                    model_load = ref_load(rw, off, n, u);
                end
            end
        end
        e.ld = model_load;
        done_q.push_back(e);
        cur_delay = delay;
        cur_rdata = rw;
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = u;
        addr = a; store_data = sd;
        seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!stall) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL access_timeout: stall never dropped, got 1 expected 0");
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // Memory model: ack after cur_delay REQ cycles; stray ack after an aborted request.
    initial begin
        int  req_cnt;
        bit  acked, req_prev;
        req_cnt = 0; acked = 0; req_prev = 0;
        forever begin
            @(negedge clk);
            dram_ack = 1'b0;
            if (dram_req) begin
                if (!acked && req_cnt == cur_delay) begin
                    dram_ack = 1'b1; dram_rdata = cur_rdata; acked = 1;
                end
                req_cnt++;
            end else begin
                if (req_prev && !acked) begin
                    dram_ack = 1'b1; dram_rdata = $urandom;
                end
                req_cnt = 0; acked = 0;
            end
            req_prev = dram_req;
        end
    end

    // Monitor: checks bus fields while requesting and completion outputs in DONE.
    initial begin
        bus_t  cb;
        done_t e;
        int    run;
        bit    prev_stall, prev_req;
        run = 0; prev_stall = 0; prev_req = 0;
        cb = '{1'b0, 32'd0, 4'b0000, 32'd0};
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0; prev_stall = 0;
            end else begin
                if (dram_req && !prev_req) begin
                    checks++;
                    if (bus_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_req: got dram_req=1 expected no request");
                    end else begin
                        cb = bus_q.pop_front();
                    end
                end
                if (dram_req) begin
                    chk("dram_we", 32'(dram_we), 32'(cb.we));
                    chk("dram_addr", dram_addr, cb.addr);
                    chk("dram_wstrb", 32'(dram_wstrb), 32'(cb.strb));
                    if (cb.we) chk("dram_wdata", dram_wdata, cb.wdata);
                end
                if (prev_stall && !stall) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: got completion expected none");
                    end else begin
                        e = done_q.pop_front();
                        chk("misalign", 32'(misalign), 32'(e.mis));
                        chk("bus_err", 32'(bus_err), 32'(e.berr));
                        chk("load_valid", 32'(load_valid), 32'(e.lv));
                        chk("load_data", load_data, e.ld);
                        chk("done_req_low", 32'(dram_req), 32'd0);
                        chk("stall_cycles", 32'(run), 32'(e.stall_len));
                    end
                end else if (misalign || bus_err || load_valid) begin
                    chk("spurious_pulse", {29'd0, misalign, bus_err, load_valid}, 32'd0);
                end
                run = stall ? run + 1 : 0;
                prev_stall = stall;
            end
            prev_req = dram_req;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_ld"}, load_data, 32'd0);
        chk({tag, "_pulses"}, {29'd0, load_valid, misalign, bus_err}, 32'd0);
        chk({tag, "_req_we"}, {30'd0, dram_req, dram_we}, 32'd0);
        chk({tag, "_addr"}, dram_addr, 32'd0);
        chk({tag, "_wstrb"}, 32'(dram_wstrb), 32'd0);
        chk({tag, "_wdata"}, dram_wdata, 32'd0);
    endtask

    initial begin
        int n, gap, kind;
        logic [1:0]  sz;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 0, 32'h80AABBCC);
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1, 32'h80AABBCC);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h042, 32'h00001234, 2, 32'h0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h0);
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h122, 32'h0, TO - 1, 32'h8001_7FFF);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 100, 32'h1234_5678);
        @(negedge clk);
        chk("late_ack_ld", load_data, 32'd0);
        chk("late_ack_state", {29'd0, stall, dram_req, load_valid}, 32'd0);

        // Reset in the second REQ cycle of a slow load.
        @(posedge clk); #1;
        bus_q.push_back('{1'b0, 32'h400, 4'b0000, 32'h0});
        cur_delay = 8; cur_rdata = 32'hCAFE_F00D;
        mem_read = 1'b1; mem_size = 2'b10; addr = 32'h400; mem_unsigned = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", 32'(dram_req), 32'd1);
        @(negedge clk);
        chk_all_zero("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_load = 32'd0;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 1, 32'h1357_9BDF);

        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            n = nbytes(sz);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
            kind = $urandom_range(0, 2);
            issue(kind != 1, kind != 0, sz, 1'($urandom_range(0, 1)), a, $urandom,
                  $urandom_range(0, TO + 1), $urandom);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
